// File: rtl/ram_dump_pkg.sv
// Shared state encoding and sizing constants for the RAM dump reader.
package ram_dump_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam int BUF_DEPTH = 2;

   // count spans 0..WORDS inclusive, so it needs one bit more than an address
   function automatic int cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/ram_dump_skid.sv
// Two-entry FIFO of {last, data} absorbing the one-cycle RAM read latency.
module ram_dump_skid
   import ram_dump_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_push,
   input  logic                  i_push_last,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic                  o_valid,
   output logic                  o_last,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_occ
);

   logic [DATA_WIDTH:0] r_mem [BUF_DEPTH];
   logic                r_wptr;
   logic                r_rptr;
   logic [1:0]          r_occ;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_occ  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= {i_push_last, i_push_data};
            r_wptr        <= ~r_wptr;
         end
         if (i_pop) r_rptr <= ~r_rptr;
         r_occ <= r_occ + 2'(i_push) - 2'(i_pop);
         // upstream issue throttling must never let a push land on a full buffer
         assert (!(i_push && !i_pop && r_occ == 2'(BUF_DEPTH)));
      end
   end

   assign o_valid = (r_occ != '0);
   assign o_last  = r_mem[r_rptr][DATA_WIDTH];
   assign o_data  = r_mem[r_rptr][DATA_WIDTH-1:0];
   assign o_occ   = r_occ;

endmodule

// File: rtl/ram_dump_reader.sv
// Streams a contiguous RAM window out on valid/ready with a last marker.
// Define RAM_DUMP_CLEAR_EN to zero each word after it has been read.
module ram_dump_reader
   import ram_dump_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = 4096
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_start,
   input  logic [ADDR_WIDTH-1:0]             i_base_addr,
   input  logic [cnt_width(ADDR_WIDTH)-1:0]  i_count,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [ADDR_WIDTH-1:0]             o_ram_r_addr,
   input  logic [DATA_WIDTH-1:0]             i_ram_r_data,
   output logic                              o_m_valid,
   input  logic                              i_m_ready,
   output logic [DATA_WIDTH-1:0]             o_m_data,
   output logic                              o_m_last
`ifdef RAM_DUMP_CLEAR_EN
   ,
   output logic                              o_ram_we,
   output logic [ADDR_WIDTH-1:0]             o_ram_w_addr,
   output logic [DATA_WIDTH-1:0]             o_ram_w_data
`endif
);

   localparam int CW = cnt_width(ADDR_WIDTH);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [CW-1:0]         r_remain;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic [1:0]            w_occ;
   logic [2:0]            w_room;
   logic                  w_pop;
   logic                  w_issue;
   logic                  w_issue_last;

   // buffer slots already claimed, counting the read still in flight
   assign w_pop        = o_m_valid & i_m_ready;
   assign w_room       = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
   assign w_issue      = (r_state == S_RUN) && (w_room < 3'(BUF_DEPTH));
   assign w_issue_last = w_issue && (r_remain == CW'(1));

   assign o_ram_r_addr = r_addr;
   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_DONE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = (i_count == '0) ? S_DONE : S_RUN;
         S_RUN:   if (w_issue_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_pop && o_m_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_addr          <= '0;
         r_remain        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue_last;
         if (r_state == S_IDLE && i_start) begin
            assert (i_count <= CW'(WORDS));
            r_addr   <= i_base_addr;
            r_remain <= i_count;
         end else if (w_issue) begin
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            r_remain <= r_remain - CW'(1);
         end
      end
   end

   ram_dump_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (r_inflight),
      .i_push_last (r_inflight_last),
      .i_push_data (i_ram_r_data),
      .i_pop       (w_pop),
      .o_valid     (o_m_valid),
      .o_last      (o_m_last),
      .o_data      (o_m_data),
      .o_occ       (w_occ)
   );

`ifdef RAM_DUMP_CLEAR_EN
   // write-first RAM: zero the word in the capture cycle, after its data is out
   logic [ADDR_WIDTH-1:0] r_iss_addr;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)     r_iss_addr <= '0;
      else if (w_issue) r_iss_addr <= r_addr;
   end

   assign o_ram_we     = r_inflight;
   assign o_ram_w_addr = r_iss_addr;
   assign o_ram_w_data = '0;
`endif

endmodule
